// File: rtl/conf_regs_shadowed_pkg.sv
// Shared constants for the shadowed configuration register file: default
// geometry, the control/status address and its request bit positions.
package conf_regs_shadowed_pkg;

  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_NUM_REGS   = 11;

  // Address map: word 0 is the request/status register, words 1.. are
  // configuration words (shadowed, then committed to the active bank).
  localparam int ADDR_CTRL      = 0;
  localparam int ADDR_FIRST_CFG = 1;

  // Bit positions inside the control/status word.
  localparam int REQ_START  = 0;
  localparam int REQ_STOP   = 1;
  localparam int REQ_FLUSH  = 2;
  localparam int REQ_COMMIT = 3;

  // Registered one-cycle request pulses.
  typedef struct packed {
    logic flush;
    logic stop;
    logic start;
  } req_t;

endpackage

// File: rtl/conf_regs_shadowed_bank.sv
// One bank of configuration words: single write port, whole-bank parallel
// load, flat output. Word 0 is never written by the write port and stays
// zero; a parallel load copies every word, so the source must keep word 0
// at zero as well.
module conf_reg_bank
  import conf_regs_shadowed_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_REGS   = DEF_NUM_REGS,
  parameter logic [DATA_WIDTH*NUM_REGS-1:0] RESET_VALUES = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           we_i,
  input  logic [ADDR_WIDTH-1:0]          waddr_i,
  input  logic [DATA_WIDTH-1:0]          wdata_i,
  input  logic                           load_i,
  input  logic [DATA_WIDTH*NUM_REGS-1:0] load_data_i,
  output logic [DATA_WIDTH*NUM_REGS-1:0] data_o
);

  logic [DATA_WIDTH-1:0] mem_q [NUM_REGS];

  // Storage: reset image, then parallel load taking priority over a write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_q[0] <= '0;
      for (int h = ADDR_FIRST_CFG; h < NUM_REGS; h++) begin
        mem_q[h] <= RESET_VALUES[h*DATA_WIDTH +: DATA_WIDTH];
      end
    end else if (load_i) begin
      for (int h = 0; h < NUM_REGS; h++) begin
        mem_q[h] <= load_data_i[h*DATA_WIDTH +: DATA_WIDTH];
      end
    end else if (we_i) begin
      for (int h = ADDR_FIRST_CFG; h < NUM_REGS; h++) begin
        if (waddr_i == ADDR_WIDTH'(h)) begin
          mem_q[h] <= wdata_i;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign data_o[g*DATA_WIDTH +: DATA_WIDTH] = mem_q[g];
  end

endmodule

// File: rtl/conf_regs_shadowed.sv
// Double-buffered configuration register file. Bus writes land in the
// shadow bank; a COMMIT request copies the whole shadow bank into the
// active bank on the first cycle acquisition is idle, so multi-word fields
// never change mid-capture. Address 0 produces one-cycle request pulses.
module conf_regs_shadowed
  import conf_regs_shadowed_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_REGS   = DEF_NUM_REGS,
  parameter logic [DATA_WIDTH*NUM_REGS-1:0] RESET_VALUES = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_en,
  input  logic [ADDR_WIDTH-1:0]          wr_addr,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  input  logic                           rd_en,
  input  logic [ADDR_WIDTH-1:0]          rd_addr,
  output logic [DATA_WIDTH-1:0]          rd_data,
  output logic                           rd_valid,
  input  logic                           acq_idle,
  output logic [DATA_WIDTH*NUM_REGS-1:0] registers,
  output logic                           commit_pending,
  output logic                           req_start,
  output logic                           req_stop,
  output logic                           req_flush
);

  logic [DATA_WIDTH*NUM_REGS-1:0] shadow_flat;
  logic                           ctrl_wr;
  logic                           commit_fire;
  req_t                           req_d, req_q;
  logic                           pending_d, pending_q;
  logic [DATA_WIDTH-1:0]          rd_word;
  logic [DATA_WIDTH-1:0]          rd_data_d, rd_data_q;
  logic                           rd_valid_q;

  assign ctrl_wr     = wr_en && (wr_addr == ADDR_WIDTH'(ADDR_CTRL));
  // The transfer samples the registered shadow, so a write landing in the
  // same cycle reaches the active bank only on a later commit.
  assign commit_fire = pending_q && acq_idle;

  conf_reg_bank #(
    .ADDR_WIDTH   (ADDR_WIDTH),
    .DATA_WIDTH   (DATA_WIDTH),
    .NUM_REGS     (NUM_REGS),
    .RESET_VALUES (RESET_VALUES)
  ) u_shadow (
    .clk         (clk),
    .rst         (rst),
    .we_i        (wr_en),
    .waddr_i     (wr_addr),
    .wdata_i     (wr_data),
    .load_i      (1'b0),
    .load_data_i ('0),
    .data_o      (shadow_flat)
  );

  conf_reg_bank #(
    .ADDR_WIDTH   (ADDR_WIDTH),
    .DATA_WIDTH   (DATA_WIDTH),
    .NUM_REGS     (NUM_REGS),
    .RESET_VALUES (RESET_VALUES)
  ) u_active (
    .clk         (clk),
    .rst         (rst),
    .we_i        (1'b0),
    .waddr_i     ('0),
    .wdata_i     ('0),
    .load_i      (commit_fire),
    .load_data_i (shadow_flat),
    .data_o      (registers)
  );

  // Request decode and commit bookkeeping; STOP wins over START.
  always_comb begin
    req_d     = '0;
    pending_d = pending_q;
    if (ctrl_wr) begin
      req_d.stop  = wr_data[REQ_STOP];
      req_d.start = wr_data[REQ_START] && !wr_data[REQ_STOP];
      req_d.flush = wr_data[REQ_FLUSH];
      if (wr_data[REQ_COMMIT]) begin
        pending_d = 1'b1;
      end
    end
    if (commit_fire) begin
      pending_d = 1'b0;
    end
  end

  // Read mux: status at address 0, shadow words above, zero out of range.
  always_comb begin
    rd_word = '0;
    if (rd_addr == ADDR_WIDTH'(ADDR_CTRL)) begin
      rd_word[REQ_COMMIT] = pending_q;
    end else begin
      for (int h = ADDR_FIRST_CFG; h < NUM_REGS; h++) begin
        if (rd_addr == ADDR_WIDTH'(h)) begin
          rd_word = shadow_flat[h*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
    rd_data_d = rd_en ? rd_word : rd_data_q;
  end

  // Control state: request pulses, commit pending flag, read response.
  always_ff @(posedge clk) begin
    if (!rst) begin
      req_q      <= '0;
      pending_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      req_q      <= req_d;
      pending_q  <= pending_d;
      rd_valid_q <= rd_en;
      rd_data_q  <= rd_data_d;
    end
  end

  assign req_start      = req_q.start;
  assign req_stop       = req_q.stop;
  assign req_flush      = req_q.flush;
  assign commit_pending = pending_q;
  assign rd_valid       = rd_valid_q;
  assign rd_data        = rd_data_q;

endmodule

// File: tb/tb_conf_regs_shadowed.sv
// Directed bench for conf_regs_shadowed: a table of single-cycle steps with
// hand-computed expectations, followed by a reset-while-pending sequence.
module tb_conf_regs_shadowed;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int NR = 11;
  // Word 7 resets to 0x0400, every other word to zero.
  localparam logic [DW*NR-1:0] RV = {16'h0000, 16'h0000, 16'h0000, 16'h0400,
                                     {7{16'h0000}}};

  logic             clk = 1'b0;
  logic             rst;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [DW-1:0]    wr_data;
  logic             rd_en;
  logic [AW-1:0]    rd_addr;
  logic [DW-1:0]    rd_data;
  logic             rd_valid;
  logic             acq_idle;
  logic [DW*NR-1:0] registers;
  logic             commit_pending;
  logic             req_start, req_stop, req_flush;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  conf_regs_shadowed #(
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW),
    .NUM_REGS     (NR),
    .RESET_VALUES (RV)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .rd_en          (rd_en),
    .rd_addr        (rd_addr),
    .rd_data        (rd_data),
    .rd_valid       (rd_valid),
    .acq_idle       (acq_idle),
    .registers      (registers),
    .commit_pending (commit_pending),
    .req_start      (req_start),
    .req_stop       (req_stop),
    .req_flush      (req_flush)
  );

  typedef struct {
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          re;
    logic [AW-1:0] ra;
    logic          idle;
    logic          exp_vld;
    logic [DW-1:0] exp_rd;
    logic          exp_pend;
    logic [2:0]    exp_req;   // {flush, stop, start}
    int            widx;
    logic [DW-1:0] wexp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic we, logic [AW-1:0] wa, logic [DW-1:0] wd,
                              logic re, logic [AW-1:0] ra, logic idle,
                              logic ev, logic [DW-1:0] erd, logic ep,
                              logic [2:0] eq, int wi, logic [DW-1:0] wx);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.re = re; v.ra = ra; v.idle = idle;
    v.exp_vld = ev; v.exp_rd = erd; v.exp_pend = ep; v.exp_req = eq;
    v.widx = wi; v.wexp = wx;
    return v;
  endfunction

  task automatic check(input string name, input logic [DW*NR-1:0] act,
                       input logic [DW*NR-1:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic we, input logic [AW-1:0] wa,
                       input logic [DW-1:0] wd, input logic re,
                       input logic [AW-1:0] ra, input logic idle);
    wr_en = we; wr_addr = wa; wr_data = wd;
    rd_en = re; rd_addr = ra; acq_idle = idle;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b0, '0, '0, 1'b0, '0, 1'b0);

    // step   we  wa     wd        re  ra     idle  vld rd        pend req     widx wexp
    vecs.push_back(mk(0, 8'd0,  16'h0000, 1, 8'd7,  0,  1, 16'h0400, 0, 3'b000, 7,  16'h0400));
    vecs.push_back(mk(1, 8'd9,  16'h0001, 0, 8'd0,  0,  0, 16'h0000, 0, 3'b000, 9,  16'h0000));
    vecs.push_back(mk(1, 8'd10, 16'h86A0, 1, 8'd9,  0,  1, 16'h0001, 0, 3'b000, 10, 16'h0000));
    vecs.push_back(mk(1, 8'd0,  16'h0008, 1, 8'd10, 0,  1, 16'h86A0, 1, 3'b000, 9,  16'h0000));
    vecs.push_back(mk(0, 8'd0,  16'h0000, 1, 8'd0,  0,  1, 16'h0008, 1, 3'b000, 10, 16'h0000));
    vecs.push_back(mk(0, 8'd0,  16'h0000, 0, 8'd0,  1,  0, 16'h0000, 0, 3'b000, 9,  16'h0001));
    vecs.push_back(mk(0, 8'd0,  16'h0000, 1, 8'd0,  0,  1, 16'h0000, 0, 3'b000, 10, 16'h86A0));
    vecs.push_back(mk(1, 8'd0,  16'h0003, 0, 8'd0,  0,  0, 16'h0000, 0, 3'b010, 10, 16'h86A0));
    vecs.push_back(mk(0, 8'd0,  16'h0000, 0, 8'd0,  0,  0, 16'h0000, 0, 3'b000, 10, 16'h86A0));
    vecs.push_back(mk(1, 8'd0,  16'h0004, 0, 8'd0,  0,  0, 16'h0000, 0, 3'b100, 10, 16'h86A0));
    vecs.push_back(mk(0, 8'd0,  16'h0000, 0, 8'd0,  0,  0, 16'h0000, 0, 3'b000, 10, 16'h86A0));
    vecs.push_back(mk(1, 8'd0,  16'h0005, 0, 8'd0,  0,  0, 16'h0000, 0, 3'b101, 10, 16'h86A0));
    vecs.push_back(mk(1, 8'd5,  16'h0011, 0, 8'd0,  0,  0, 16'h0000, 0, 3'b000, 5,  16'h0000));
    vecs.push_back(mk(1, 8'd0,  16'h0008, 0, 8'd0,  1,  0, 16'h0000, 1, 3'b000, 5,  16'h0000));
    vecs.push_back(mk(1, 8'd5,  16'h00AA, 0, 8'd0,  1,  0, 16'h0000, 0, 3'b000, 5,  16'h0011));
    vecs.push_back(mk(0, 8'd0,  16'h0000, 1, 8'd5,  0,  1, 16'h00AA, 0, 3'b000, 5,  16'h0011));
    vecs.push_back(mk(0, 8'd0,  16'h0000, 1, 8'h20, 0,  1, 16'h0000, 0, 3'b000, 5,  16'h0011));
    vecs.push_back(mk(0, 8'd0,  16'h0000, 1, 8'd10, 0,  1, 16'h86A0, 0, 3'b000, 9,  16'h0001));
    vecs.push_back(mk(0, 8'd0,  16'h0000, 1, 8'd9,  0,  1, 16'h0001, 0, 3'b000, 9,  16'h0001));
    vecs.push_back(mk(0, 8'd0,  16'h0000, 0, 8'd0,  0,  0, 16'h0000, 0, 3'b000, 9,  16'h0001));
    vecs.push_back(mk(1, 8'd11, 16'hFFFF, 0, 8'd0,  0,  0, 16'h0000, 0, 3'b000, 0,  16'h0000));
    vecs.push_back(mk(0, 8'd0,  16'h0000, 1, 8'd11, 0,  1, 16'h0000, 0, 3'b000, 0,  16'h0000));
    vecs.push_back(mk(1, 8'd7,  16'h1234, 1, 8'd7,  0,  1, 16'h0400, 0, 3'b000, 7,  16'h0400));
    vecs.push_back(mk(0, 8'd0,  16'h0000, 1, 8'd7,  0,  1, 16'h1234, 0, 3'b000, 7,  16'h0400));

    // Reset state
    repeat (2) step();
    check("reset_registers", registers, RV);
    check("reset_pending", {175'b0, commit_pending}, '0);
    check("reset_rd_valid", {175'b0, rd_valid}, '0);
    check("reset_rd_data", {160'b0, rd_data}, '0);
    check("reset_req", {173'b0, req_flush, req_stop, req_start}, '0);
    rst = 1'b1;

    // Table-driven steps
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].re, vecs[i].ra,
            vecs[i].idle);
      step();
      check($sformatf("v%0d_rd_valid", i), {175'b0, rd_valid},
            {175'b0, vecs[i].exp_vld});
      if (vecs[i].exp_vld)
        check($sformatf("v%0d_rd_data", i), {160'b0, rd_data},
              {160'b0, vecs[i].exp_rd});
      check($sformatf("v%0d_pending", i), {175'b0, commit_pending},
            {175'b0, vecs[i].exp_pend});
      check($sformatf("v%0d_req", i), {173'b0, req_flush, req_stop, req_start},
            {173'b0, vecs[i].exp_req});
      check($sformatf("v%0d_word%0d", i, vecs[i].widx),
            {160'b0, registers[vecs[i].widx*DW +: DW]}, {160'b0, vecs[i].wexp});
    end

    // Reset while a commit is pending
    drive(1'b1, 8'd0, 16'h0008, 1'b0, 8'd0, 1'b0);
    step();
    check("mid_pending_set", {175'b0, commit_pending}, {175'b0, 1'b1});
    rst = 1'b0;
    drive(1'b1, 8'd0, 16'h0007, 1'b1, 8'd0, 1'b1);
    step();
    check("mid_rst_pending", {175'b0, commit_pending}, '0);
    check("mid_rst_rd_valid", {175'b0, rd_valid}, '0);
    check("mid_rst_rd_data", {160'b0, rd_data}, '0);
    check("mid_rst_req", {173'b0, req_flush, req_stop, req_start}, '0);
    check("mid_rst_registers", registers, RV);
    rst = 1'b1;
    drive(1'b1, 8'd3, 16'h5555, 1'b0, 8'd0, 1'b1);
    step();
    check("post_rst_pending", {175'b0, commit_pending}, '0);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 8'd0, 16'h0000, 1'b1, 8'd3, 1'b1);
      step();
      check($sformatf("post_rst_idle%0d_registers", k), registers, RV);
      check($sformatf("post_rst_idle%0d_pending", k), {175'b0, commit_pending}, '0);
      check($sformatf("post_rst_idle%0d_rd3", k), {160'b0, rd_data},
            {160'b0, 16'h5555});
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/conf_regs_shadowed.md
# conf_regs_shadowed

Double-buffered configuration register file that replaces direct bit-array exposure of the configuration registers. Bus writes land in a shadow bank and are transferred atomically to the active bank only on an explicit commit while acquisition is idle, so multi-word fields such as decimation factor, num_samples and pre_trigger never change mid-capture. Address 0 is a self-clearing request/status register that produces one-cycle request pulses. The active bank drives the existing named-net wrapper unchanged.

## Interface
- ADDR_WIDTH, 8, register address width
- DATA_WIDTH, 16, register word width
- NUM_REGS, 11, registers including address 0; legal addresses 0..NUM_REGS-1
- RESET_VALUES, all zero, DATA_WIDTH*NUM_REGS reset image, applied to both banks; word 0 ignored
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- wr_en  in  1  write strobe, one word per cycle
- wr_addr  in  ADDR_WIDTH  write address
- wr_data  in  DATA_WIDTH  write data
- rd_en  in  1  read strobe
- rd_addr  in  ADDR_WIDTH  read address
- rd_data  out  DATA_WIDTH  read data, valid with rd_valid
- rd_valid  out  1  one-cycle read-data qualifier
- acq_idle  in  1  acquisition idle; commits are allowed only while high
- registers  out  DATA_WIDTH*NUM_REGS  active bank, word h at bits [(h+1)*DATA_WIDTH-1 : h*DATA_WIDTH]; word 0 always zero
- commit_pending  out  1  commit requested, not yet applied
- req_start, req_stop, req_flush  out  1 each  one-cycle request pulses

## Operation
- Address 0 write bits: 0 START, 1 STOP, 2 FLUSH, 3 COMMIT; other bits ignored; no storage.
- START/STOP/FLUSH: the matching req_* output pulses high for exactly one cycle, the cycle after the write. If START and STOP are written together, STOP pulses and START is suppressed. FLUSH is independent.
- COMMIT sets commit_pending. Writing COMMIT again while pending is a no-op.
- Commit transfer: in any cycle with commit_pending=1 and acq_idle=1, every shadow word 1..NUM_REGS-1 is copied to the active bank, and commit_pending clears on the same edge. This is all-or-nothing; no partial transfer.
- Writes to address 1..NUM_REGS-1 update the shadow word only. Writes to address ≥ NUM_REGS are ignored.
- Write coinciding with a commit transfer: the active bank takes the pre-write shadow value, and the shadow holds the new value.
- COMMIT written while acq_idle=1 and not pending: the transfer occurs on the following cycle. The write cycle itself only sets pending.
- Reads:
  - Address 0 returns {zeros, commit_pending at bit 3, zeros}.
  - Address 1..NUM_REGS-1 returns the shadow word.
  - Out-of-range addresses return 0.
- A read of a word written in the same cycle returns the old value.
- Reset, including mid-pending: both banks load RESET_VALUES, commit_pending=0, rd_valid=0, rd_data=0, all req_* = 0. A pending commit is discarded.

## Timing
- Request pulse latency: 1 cycle after the wr_en edge.
- Read latency: 1 cycle; rd_valid is high exactly one cycle per rd_en. Back-to-back reads are allowed every cycle.
- Commit latency: registers changes on the first rising edge where pending and acq_idle are both high. With acq_idle held low, pending persists indefinitely.
- registers is a direct register output with no combinational path from bus inputs.

## Structure
- Shared package/include (extend conf_regs_defines): address map constants, REQ_START/REQ_STOP/REQ_FLUSH/REQ_COMMIT bit indices, default ADDR_WIDTH/DATA_WIDTH/NUM_REGS.
- One natural sub-module: conf_reg_bank (NUM_REGS×DATA_WIDTH storage with write port, parallel load, flat output), instantiated twice for shadow and active.
- Request-pulse and commit logic live in the top module.

## Test plan
- Reset: drive rst=0 with RESET_VALUES word 7 = 0x0400 → registers word 7 = 0x0400, read addr 7 = 0x0400, all outputs otherwise zero.
- Shadow isolation: write addr 9 = 0x0001 and addr 10 = 0x86A0 with acq_idle=0, then COMMIT (0x0008) → registers unchanged and commit_pending=1. Raise acq_idle → both words update on the same edge, pending=0.
- Requests: write addr 0 = 0x0003 → req_stop pulses one cycle, req_start stays 0. Write 0x0004 → req_flush pulses once.
- Collision: pending commit, acq_idle=1, write addr 5 = 0x00AA in the transfer cycle → active word 5 holds the old shadow value, read addr 5 = 0x00AA.
- Reads: addr 0 while pending → 0x0008. Addr 0x20 → 0x0000. Each read gets rd_valid one cycle later, and back-to-back reads return data in order.
- Reset mid-pending: assert rst with pending=1 → pending=0, no transfer after reset release even with acq_idle=1.
